scale_demux: RTL and testbench

//  Registered 1-to-2 demultiplexer, the steering counterpart of scale_mux: one valid/ready

---
 rtl/scale_demux_pkg.sv | 13 +
 rtl/scale_demux_if.sv | 31 +++
 rtl/scale_demux_buf2.sv | 64 ++++++
 rtl/scale_demux_chk.sv | 37 +++
 rtl/scale_demux.sv | 96 +++++++++
 tb/tb_scale_demux.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/scale_demux_pkg.sv
// Shared types for the scale_demux steering block: per-output buffer occupancy
// states and the buffer depth.
package scale_demux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int DEMUX_DEPTH = 2;

endpackage

// File: rtl/scale_demux_if.sv
// Stream bundle of scale_demux: one valid/ready input, two valid/ready outputs
// and the per-output accepted-beat counters.
interface scale_demux_if #(
    parameter int width = 1,
    parameter int cnt_w = 8
) ();

    logic [0:width-1] in_data;
    logic             in_valid;
    logic             in_sel_a;
    logic             in_ready;
    logic [0:width-1] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [0:width-1] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [cnt_w-1:0] a_count;
    logic [cnt_w-1:0] b_count;

    modport master (
        output in_data, in_valid, in_sel_a, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport slave (
        input  in_data, in_valid, in_sel_a, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

endinterface

// File: rtl/scale_demux_buf2.sv
// Two-entry in-order buffer for one demux output: entry 0 is always the head,
// entry 1 only holds a beat while the buffer is TWO.
module scale_demux_buf2
    import scale_demux_pkg::*;
#(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic             pop,
    input  logic [0:width-1] d,
    output logic             full,
    output logic             valid,
    output logic [0:width-1] head
);

    buf_state_e       state_r;
    logic [0:width-1] mem_r [0:DEMUX_DEPTH-1];

    // Occupancy FSM and storage; a push to a full buffer or a pop of an empty one is ignored.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= EMPTY;
            for (int i = 0; i < DEMUX_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push) begin
                        mem_r[0] <= d;
                        state_r  <= ONE;
                    end
                end
                ONE: begin
                    // Simultaneous push and pop replaces the head and stays ONE.
                    if (push && pop) begin
                        mem_r[0] <= d;
                    end else if (push) begin
                        mem_r[1] <= d;
                        state_r  <= TWO;
                    end else if (pop) begin
                        state_r  <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        mem_r[0] <= mem_r[1];
                        state_r  <= ONE;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    assign full  = (state_r == TWO);
    assign valid = (state_r != EMPTY);
    assign head  = mem_r[0];

endmodule

// File: rtl/scale_demux_chk.sv
// Protocol checker for the scale_demux input: a stalled beat must be held
// unchanged, and the select must be known whenever a beat is offered.
module scale_demux_chk #(
    parameter int width = 1
) (
    input logic             clk,
    input logic             rst_,
    input logic             in_valid,
    input logic             in_ready,
    input logic             in_sel_a,
    input logic [0:width-1] in_data
);

    logic             stall_r;
    logic             sel_r;
    logic [0:width-1] data_r;

    // Remember whether last cycle's beat was refused, and what it carried.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stall_r <= 1'b0;
            sel_r   <= 1'b0;
            data_r  <= '0;
        end else begin
            stall_r <= in_valid && !in_ready;
            sel_r   <= in_sel_a;
            data_r  <= in_data;
        end
    end

    held_beat_stable: assert property (@(posedge clk) disable iff (!rst_)
        (stall_r && in_valid) |-> (in_sel_a == sel_r && in_data == data_r));

    select_known: assert property (@(posedge clk) disable iff (!rst_)
        in_valid |-> !$isunknown(in_sel_a));

endmodule

// File: rtl/scale_demux.sv
// Registered 1-to-2 stream demultiplexer: each beat is steered to output A or B
// by in_sel_a and lands in that output's own two-entry buffer.
module scale_demux
    import scale_demux_pkg::*;
#(
    parameter int width = 1,
    parameter int cnt_w = 8
) (
    input logic          clk,
    input logic          rst_,
    scale_demux_if.slave bus
);

    localparam logic [cnt_w-1:0] CNT_ONE = cnt_w'(1'b1);

    logic             a_full_s;
    logic             b_full_s;
    logic             push_a_s;
    logic             push_b_s;
    logic             ready_s;
    logic [cnt_w-1:0] a_count_r;
    logic [cnt_w-1:0] b_count_r;

    // Select decode: readiness depends only on the select and buffer occupancy,
    // never on the consumers' ready, so a pop cannot open the input in the same cycle.
    always_comb begin
        push_a_s = 1'b0;
        push_b_s = 1'b0;
        ready_s  = 1'b0;
        unique case (bus.in_sel_a)
            1'b1: begin
                ready_s  = !a_full_s;
                push_a_s = bus.in_valid && !a_full_s;
            end
            1'b0: begin
                ready_s  = !b_full_s;
                push_b_s = bus.in_valid && !b_full_s;
            end
            default: begin
                ready_s  = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = ready_s;

    // Accepted-beat counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            a_count_r <= '0;
            b_count_r <= '0;
        end else begin
            if (push_a_s) begin
                a_count_r <= a_count_r + CNT_ONE;
            end
            if (push_b_s) begin
                b_count_r <= b_count_r + CNT_ONE;
            end
        end
    end

    assign bus.a_count = a_count_r;
    assign bus.b_count = b_count_r;

    scale_demux_buf2 #(.width(width)) u_buf_a (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push_a_s),
        .pop   (bus.a_ready),
        .d     (bus.in_data),
        .full  (a_full_s),
        .valid (bus.a_valid),
        .head  (bus.a_data)
    );

    scale_demux_buf2 #(.width(width)) u_buf_b (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push_b_s),
        .pop   (bus.b_ready),
        .d     (bus.in_data),
        .full  (b_full_s),
        .valid (bus.b_valid),
        .head  (bus.b_data)
    );

    scale_demux_chk #(.width(width)) u_chk (
        .clk      (clk),
        .rst_     (rst_),
        .in_valid (bus.in_valid),
        .in_ready (ready_s),
        .in_sel_a (bus.in_sel_a),
        .in_data  (bus.in_data)
    );

endmodule

// File: tb/tb_scale_demux.sv
// Self-checking bench for scale_demux: directed vector table, hand-written
// reset/wrap sequences, and randomized traffic against a queue-based model.
module tb_scale_demux;

    logic clk;
    logic rst_;
    int   n_vec;
    int   n_fail;

    scale_demux_if #(.width(8), .cnt_w(8)) bus ();

    scale_demux #(.width(8), .cnt_w(8)) u_dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       sel;
        logic [7:0] d;
        logic       ar;
        logic       br;
        logic       rdy;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic [7:0] ac;
        logic [7:0] bc;
    } vec_t;

    vec_t tbl [15];

    // Reference model state: per-output FIFOs of beats, held head values, counts.
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] m_ad, m_bd, m_ac, m_bc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [7:0] d,
                         input logic ar, input logic br);
        bus.in_valid = v;
        bus.in_sel_a = sel;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic av, input logic [7:0] ad,
                            input logic bv, input logic [7:0] bd,
                            input logic [7:0] ac, input logic [7:0] bc);
        chk({tag, ".a_valid"}, {31'd0, bus.a_valid}, {31'd0, av});
        chk({tag, ".a_data"},  {24'd0, bus.a_data},  {24'd0, ad});
        chk({tag, ".b_valid"}, {31'd0, bus.b_valid}, {31'd0, bv});
        chk({tag, ".b_data"},  {24'd0, bus.b_data},  {24'd0, bd});
        chk({tag, ".a_count"}, {24'd0, bus.a_count}, {24'd0, ac});
        chk({tag, ".b_count"}, {24'd0, bus.b_count}, {24'd0, bc});
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        rst_ = 1'b0;
        #1;
        chk_outs("reset", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_ = 1'b1;
        tick();
        qa.delete();
        qb.delete();
        m_ad = 8'h00;
        m_bd = 8'h00;
        m_ac = 8'h00;
        m_bc = 8'h00;
    endtask

    initial begin
        logic       pend;
        logic       exp_rdy;
        logic       v, sel, ar, br;
        logic [7:0] d;

        n_vec  = 0;
        n_fail = 0;
        rst_   = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        do_reset();

        // Directed table: {v, sel, d, a_ready, b_ready, in_ready, a_v, a_d, b_v, b_d, a_cnt, b_cnt}
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'd1, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h3C, 8'd1, 8'd1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h3C, 8'd1, 8'd1};
        tbl[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h3C, 8'd2, 8'd1};
        tbl[4]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h3C, 8'd3, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h3C, 8'd3, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h3C, 8'd3, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h3C, 8'd3, 8'd1};
        tbl[8]  = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h44, 8'd3, 8'd2};
        tbl[9]  = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 8'h44, 8'd3, 8'd2};
        tbl[10] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 8'd4, 8'd2};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 8'h44, 8'd4, 8'd2};
        tbl[12] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'h44, 8'd5, 8'd2};
        tbl[13] = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'h44, 8'd6, 8'd2};
        tbl[14] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 8'h44, 8'd6, 8'd2};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br);
            #1;
            chk($sformatf("tbl%0d.in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].rdy});
            tick();
            chk_outs($sformatf("tbl%0d", i), tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd,
                     tbl[i].ac, tbl[i].bc);
        end

        // Fill both buffers to TWO, then reset asynchronously in mid-cycle.
        drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 8'h02, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 8'h04, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        #1;
        chk("full.in_ready_a", {31'd0, bus.in_ready}, 32'd0);
        bus.in_sel_a = 1'b0;
        #1;
        chk("full.in_ready_b", {31'd0, bus.in_ready}, 32'd0);
        chk_outs("full", 1'b1, 8'h01, 1'b1, 8'h03, 8'd8, 8'd4);
        do_reset();

        // 256 beats to B wrap its counter back to 0 and leave A untouched.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
            tick();
            if (i == 254) begin
                chk("wrap.b_count_255", {24'd0, bus.b_count}, 32'd255);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk_outs("wrap", 1'b0, 8'h00, 1'b1, 8'hFF, 8'd0, 8'd0);
        tick();
        do_reset();

        // Randomized traffic against the queue model, with one reset mid-run.
        pend = 1'b0;
        v = 1'b0; sel = 1'b0; d = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                do_reset();
                pend = 1'b0;
            end
            if (!pend) begin
                v   = ($urandom_range(0, 3) != 0);
                sel = 1'($urandom);
                d   = 8'($urandom);
            end
            ar = ($urandom_range(0, 99) < ((cyc / 500) % 2 == 0 ? 35 : 80));
            br = ($urandom_range(0, 99) < ((cyc / 500) % 2 == 0 ? 80 : 35));
            drive(v, sel, d, ar, br);
            #1;
            exp_rdy = sel ? (qa.size() < 2) : (qb.size() < 2);
            chk("rnd.in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            @(posedge clk);
            if (ar && qa.size() > 0) void'(qa.pop_front());
            if (br && qb.size() > 0) void'(qb.pop_front());
            if (v && exp_rdy) begin
                if (sel) begin
                    qa.push_back(d);
                    m_ac = m_ac + 8'd1;
                end else begin
                    qb.push_back(d);
                    m_bc = m_bc + 8'd1;
                end
            end
            pend = v && !exp_rdy;
            if (qa.size() > 0) m_ad = qa[0];
            if (qb.size() > 0) m_bd = qb[0];
            #1;
            chk_outs("rnd", qa.size() > 0, m_ad, qb.size() > 0, m_bd, m_ac, m_bc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
